csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode control/status register file for the RV32I core; sits beside the decode/execute stage.
- Serves CSR instructions through one 12-bit-addressed read/write port.
- Gives the trap logic direct read access to mtvec, mepc and mcause, and dedicated write ports for mepc and mcause.

Parameters:
- MISA_VALUE, 32'h4000_0100, constant returned for misa (MXL=1 for RV32, extension bit I).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- we  in  1  write enable for the main CSR port.
- a  in  12  CSR address for main read/write.
- din  in  32  main write data.
- dout  out  32  main read data, combinational from a.
- mepc_dout  out  32  current mepc value.
- mtvec_dout  out  32  current mtvec value.
- mcause_dout  out  32  current mcause value.
- mepc_we  in  1  trap-side write enable for mepc.
- mepc_din  in  32  trap-side mepc write data.
- mcause_we  in  1  trap-side write enable for mcause.
- mcause_din  in  32  trap-side mcause write data.

Behaviour:
- Reset (reset==0 at rising clk): mtvec, mscratch, mepc and mcause all become 0. mtvec_dout, mepc_dout and mcause_dout read 0 right after that edge.
- Reads: dout is purely combinational from a and the current register state. No read latency.
- Writes: take effect on the rising clk edge where the write enable is 1. The new value is visible on dout and the direct outputs right after that edge, i.e. one cycle of write latency.
- Register map (main port):
  - 0x301 misa: read-only, always returns MISA_VALUE. Writes are ignored.
  - 0x305 mtvec: read/write, WARL. A write is accepted only if din[1:0] is 2'b00 (direct) or 2'b01 (vectored). If din[1:0] is 2'b10 or 2'b11, the whole write is dropped and the old value is kept.
  - 0x340 mscratch: read/write, all 32 bits stored.
  - 0x341 mepc: read/write, all 32 bits stored.
  - 0x342 mcause: readable; main-port writes are ignored. It is written only via mcause_we.
  - Any other address reads 0; writes to it are ignored with no side effects.
- Trap ports:
  - mepc_we=1 loads mepc_din into mepc.
  - mcause_we=1 loads mcause_din into mcause.
  - Both are independent of we and a, and may be asserted in the same cycle as each other.
- Simultaneous main write to 0x341 with mepc_we=1: the trap port wins and mepc takes mepc_din.
- Reset has priority over every write in the same cycle.

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- With it defined:
  - A 64-bit cycle counter is added. It resets to 0 and increments by 1 every clk when not in reset, wrapping at 2^64 to 0.
  - It is readable at 0xB00 (low word), 0xB80 (high word), 0xC00 (cycle, low) and 0xC80 (cycleh, high).
  - A main-port write to 0xB00 or 0xB80 loads that half. The loaded value appears on the following read, and counting resumes from it.
  - Writes to 0xC00 and 0xC80 are ignored.
- Without it: those addresses behave as unimplemented (read 0, writes ignored) and no counter logic is synthesized.

Decomposition:
- Package csr_pkg holds:
  - 12-bit address localparams: CSR_MISA, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH, CSR_CYCLE, CSR_CYCLEH.
  - Default MISA constant.
  - mtvec mode enum: DIRECT=2'b00, VECTORED=2'b01.
- One sub-module, csr_cycle_counter (64-bit counter with per-half load), instantiated only under CSR_MCYCLE_EN.
- The rest is flat in csr_file.

Test Plan:
- Reset: drive reset=0 for one edge -> mtvec_dout, mepc_dout and mcause_dout all 0. a=0x305 and a=0x341 give dout=0; a=0x301 gives dout=32'h4000_0100.
- misa read-only: a=0x301, we=1, din=420 -> dout stays 32'h4000_0100.
- mtvec WARL, as a sequence on a=0x305:
  - we=0, din=0xFC -> dout=0.
  - we=1, din=0xFC -> dout=0xFC.
  - din=0xFF, then din=0xFE -> dout stays 0xFC.
  - din=0xFD -> dout=0xFD.
- mscratch/mepc main-port writes:
  - a=0x340, we=0 -> dout=0; then we=1, din=45446848 -> dout=45446848.
  - a=0x341, we=1, din=86492168 -> dout=86492168 and mepc_dout matches.
- mcause isolation: a=0x342, we=1, din=508943 -> dout=0.
- Trap ports:
  - mepc_we=1, mepc_din=80 -> mepc_dout=80; then mepc_we=0, mepc_din=0 -> stays 80.
  - mcause_we=1, mcause_din=986 -> 986; then mcause_we=0, mcause_din=20 -> stays 986.
  - mepc_we=1 together with a main write to 0x341 -> mepc takes mepc_din.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file:
// CSR addresses, the misa default and the mtvec mode encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

    localparam logic [31:0] MISA_DEFAULT = 32'h4000_0100;

    typedef enum logic [1:0] {
        DIRECT   = 2'b00,
        VECTORED = 2'b01
    } mtvec_mode_e;

    function automatic logic mtvec_mode_legal(input logic [1:0] mode);
        return (mode == DIRECT) || (mode == VECTORED);
    endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// 64-bit free-running cycle counter with a separate load for each half.
// Ports: clk, reset (sync, active-low), lo_we/hi_we + din load, count out.
module csr_cycle_counter
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [31:0] din,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // A loaded half replaces the incremented value, so the loaded
    // value is what gets read next and counting resumes from it.
    always_comb begin
        count_d = count_q + 64'd1;
        if (lo_we) begin
            count_d[31:0] = din;
        end
        if (hi_we) begin
            count_d[63:32] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: one 12-bit addressed read/write port plus
// direct trap-side access to mtvec/mepc/mcause.
// Ports: clk, reset (sync, active-low), we/a/din/dout main port,
// mepc/mtvec/mcause direct outputs, mepc_we/din and mcause_we/din.
// Optional: define CSR_MCYCLE_EN to add the 64-bit mcycle counter.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = MISA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [11:0] a,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] mepc_dout,
    output logic [31:0] mtvec_dout,
    output logic [31:0] mcause_dout,
    input  logic        mepc_we,
    input  logic [31:0] mepc_din,
    input  logic        mcause_we,
    input  logic [31:0] mcause_din
);

    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

`ifdef CSR_MCYCLE_EN
    logic [63:0] cycle_count;
    logic        cyc_lo_we;
    logic        cyc_hi_we;

    assign cyc_lo_we = we && (a == CSR_MCYCLE);
    assign cyc_hi_we = we && (a == CSR_MCYCLEH);

    csr_cycle_counter u_cycle (
        .clk   (clk),
        .reset (reset),
        .lo_we (cyc_lo_we),
        .hi_we (cyc_hi_we),
        .din   (din),
        .count (cycle_count)
    );
`endif

    always_comb begin
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        // Illegal mode bits drop the whole mtvec write.
        if (we && (a == CSR_MTVEC) && mtvec_mode_legal(din[1:0])) begin
            mtvec_d = din;
        end
        if (we && (a == CSR_MSCRATCH)) begin
            mscratch_d = din;
        end
        // Trap-side write wins over a same-cycle main-port write.
        if (mepc_we) begin
            mepc_d = mepc_din;
        end else if (we && (a == CSR_MEPC)) begin
            mepc_d = din;
        end
        if (mcause_we) begin
            mcause_d = mcause_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    always_comb begin
        dout = '0;
        case (a)
            CSR_MISA:     dout = MISA_VALUE;
            CSR_MTVEC:    dout = mtvec_q;
            CSR_MSCRATCH: dout = mscratch_q;
            CSR_MEPC:     dout = mepc_q;
            CSR_MCAUSE:   dout = mcause_q;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE:   dout = cycle_count[31:0];
            CSR_MCYCLEH:  dout = cycle_count[63:32];
            CSR_CYCLE:    dout = cycle_count[31:0];
            CSR_CYCLEH:   dout = cycle_count[63:32];
`endif
            default:      dout = '0;
        endcase
    end

    assign mepc_dout   = mepc_q;
    assign mtvec_dout  = mtvec_q;
    assign mcause_dout = mcause_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed steps, expected values
// queued as stimulus is applied and compared when outputs settle.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [11:0] a;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] mepc_dout;
    logic [31:0] mtvec_dout;
    logic [31:0] mcause_dout;
    logic        mepc_we;
    logic [31:0] mepc_din;
    logic        mcause_we;
    logic [31:0] mcause_din;

    localparam int SEL_DOUT   = 0;
    localparam int SEL_MEPC   = 1;
    localparam int SEL_MTVEC  = 2;
    localparam int SEL_MCAUSE = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;

    csr_file dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .a           (a),
        .din         (din),
        .dout        (dout),
        .mepc_dout   (mepc_dout),
        .mtvec_dout  (mtvec_dout),
        .mcause_dout (mcause_dout),
        .mepc_we     (mepc_we),
        .mepc_din    (mepc_din),
        .mcause_we   (mcause_we),
        .mcause_din  (mcause_din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input logic [31:0] v, input string tag);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = v;
        q.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        while (q.size() > 0) begin
            it = q.pop_front();
            case (it.sel)
                SEL_MEPC:   obs = mepc_dout;
                SEL_MTVEC:  obs = mtvec_dout;
                SEL_MCAUSE: obs = mcause_dout;
                default:    obs = dout;
            endcase
            checks++;
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] v, input string tag);
        we = 1'b0;
        a  = addr;
        #1;
        push(SEL_DOUT, v, tag);
        drain();
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        a   = addr;
        din = data;
        we  = 1'b1;
        tick();
        we  = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        we         = 1'b0;
        a          = '0;
        din        = '0;
        mepc_we    = 1'b0;
        mepc_din   = '0;
        mcause_we  = 1'b0;
        mcause_din = '0;

        // reset
        tick();
        reset = 1'b1;
        push(SEL_MTVEC, 32'h0, "rst_mtvec");
        push(SEL_MEPC, 32'h0, "rst_mepc");
        push(SEL_MCAUSE, 32'h0, "rst_mcause");
        drain();
        rd(12'h305, 32'h0, "rst_rd_mtvec");
        rd(12'h341, 32'h0, "rst_rd_mepc");
        rd(12'h301, 32'h4000_0100, "rst_rd_misa");

        // misa read-only
        wr(12'h301, 32'd420);
        rd(12'h301, 32'h4000_0100, "misa_ro");

        // mtvec WARL
        a   = 12'h305;
        din = 32'hFC;
        tick();
        rd(12'h305, 32'h0, "mtvec_no_we");
        wr(12'h305, 32'hFC);
        rd(12'h305, 32'hFC, "mtvec_direct");
        push(SEL_MTVEC, 32'hFC, "mtvec_dout");
        drain();
        wr(12'h305, 32'hFF);
        rd(12'h305, 32'hFC, "mtvec_mode3");
        wr(12'h305, 32'hFE);
        rd(12'h305, 32'hFC, "mtvec_mode2");
        wr(12'h305, 32'hFD);
        rd(12'h305, 32'hFD, "mtvec_vectored");

        // mscratch / mepc
        rd(12'h340, 32'h0, "mscratch_init");
        wr(12'h340, 32'd45446848);
        rd(12'h340, 32'd45446848, "mscratch_wr");
        wr(12'h341, 32'd86492168);
        rd(12'h341, 32'd86492168, "mepc_wr");
        push(SEL_MEPC, 32'd86492168, "mepc_dout_wr");
        drain();

        // mcause isolated from main port
        wr(12'h342, 32'd508943);
        rd(12'h342, 32'h0, "mcause_ro");

        // unimplemented address
        wr(12'h123, 32'hDEAD_BEEF);
        rd(12'h123, 32'h0, "unimpl");

        // trap ports
        mepc_we  = 1'b1;
        mepc_din = 32'd80;
        tick();
        mepc_we  = 1'b0;
        mepc_din = 32'd0;
        push(SEL_MEPC, 32'd80, "trap_mepc");
        drain();
        tick();
        push(SEL_MEPC, 32'd80, "trap_mepc_hold");
        drain();

        mcause_we  = 1'b1;
        mcause_din = 32'd986;
        tick();
        mcause_we  = 1'b0;
        mcause_din = 32'd20;
        push(SEL_MCAUSE, 32'd986, "trap_mcause");
        drain();
        tick();
        push(SEL_MCAUSE, 32'd986, "trap_mcause_hold");
        drain();

        // trap port beats main write; both trap ports together
        mepc_we    = 1'b1;
        mepc_din   = 32'h0000_1234;
        mcause_we  = 1'b1;
        mcause_din = 32'h8000_0007;
        wr(12'h341, 32'hCAFE_0000);
        mepc_we   = 1'b0;
        mcause_we = 1'b0;
        push(SEL_MEPC, 32'h0000_1234, "mepc_prio");
        push(SEL_MCAUSE, 32'h8000_0007, "mcause_dual");
        drain();
        rd(12'h341, 32'h0000_1234, "mepc_prio_rd");

        // reset beats a same-cycle write
        reset = 1'b0;
        wr(12'h340, 32'h5555_AAAA);
        reset = 1'b1;
        rd(12'h340, 32'h0, "rst_prio_mscratch");
        push(SEL_MEPC, 32'h0, "rst_prio_mepc");
        push(SEL_MCAUSE, 32'h0, "rst_prio_mcause");
        push(SEL_MTVEC, 32'h0, "rst_prio_mtvec");
        drain();

`ifdef CSR_MCYCLE_EN
        wr(12'hB00, 32'd100);
        rd(12'hB00, 32'd100, "mcycle_load");
        tick();
        rd(12'hC00, 32'd101, "cycle_count");
        wr(12'hB80, 32'd7);
        rd(12'hB80, 32'd7, "mcycleh_load");
        rd(12'hC80, 32'd7, "cycleh_rd");
        wr(12'hC00, 32'd0);
        rd(12'hB80, 32'd7, "cycle_ro");
`else
        wr(12'hB00, 32'd100);
        rd(12'hB00, 32'h0, "mcycle_absent");
        rd(12'hC00, 32'h0, "cycle_absent");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
